bht_predictor: RTL and testbench



---
 rtl/bht_predictor.sv | 141 ++++++++++++++
 tb/tb_bht_predictor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_predictor.sv
// Direct-mapped branch history table + target buffer; lookup and redirect are combinational (0 cycles), training lands at the next clk edge.
// No backpressure: one lookup and one EX resolution per clock; EX inputs are ignored until the INIT sweep has cleared the table.
module bht_predictor #(
  parameter int IDX_W = 6,
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc,
  output logic [31:0]      pc_predict,
  output logic             pred_taken,
  output logic             ready,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             predict_fail,
  output logic [31:0]      pc_new,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;
  localparam int HI_W  = 30 - PC_W;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic             r_vld [N];
  logic [TAG_W-1:0] r_tag [N];
  logic [PC_W-1:0]  r_tgt [N];
  logic [1:0]       r_ctr [N];

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_sweep;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic             w_run;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_pred_taken;
  logic [PC_W-1:0]  w_pc_seq;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic             w_ex_act;
  logic             w_fail_br;
  logic             w_fail;
  logic [PC_W-1:0]  w_ex_seq;
  logic [PC_W-1:0]  w_new_word;
  logic             w_unused_bits;

  assign w_run = (r_state == S_RUN);

  // Fetch-side lookup
  assign w_idx        = pc[IDX_W+1:2];
  assign w_tag        = pc[PC_W+1:IDX_W+2];
  assign w_hit        = r_vld[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_pred_taken = w_run && w_hit && r_ctr[w_idx][1];
  assign w_pc_seq     = pc[PC_W+1:2] + PC_W'(1);

  assign pred_taken = w_pred_taken;
  assign pc_predict = w_pred_taken ? {{HI_W{1'b0}}, r_tgt[w_idx], 2'b00}
                                   : {{HI_W{1'b0}}, w_pc_seq, 2'b00};
  assign ready      = w_run;

  // EX-side resolution
  assign w_ex_idx  = ex_pc[IDX_W+1:2];
  assign w_ex_tag  = ex_pc[PC_W+1:IDX_W+2];
  assign w_ex_hit  = r_vld[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_act  = ex_valid && w_run;
  assign w_fail_br = (ex_taken != ex_pred_taken) || (ex_taken && (ex_pred_target != ex_target));
  assign w_fail    = w_ex_act && (ex_is_branch ? w_fail_br : ex_pred_taken);
  assign w_ex_seq  = ex_pc[PC_W+1:2] + PC_W'(1);
  assign w_new_word = (ex_is_branch && ex_taken) ? ex_target[PC_W+1:2] : w_ex_seq;

  assign predict_fail = w_fail;
  assign pc_new       = w_fail ? {{HI_W{1'b0}}, w_new_word, 2'b00} : 32'd0;
  assign branch_cnt   = r_branch_cnt;
  assign miss_cnt     = r_miss_cnt;

  assign w_unused_bits = ^{pc[31:PC_W+2], pc[1:0], ex_pc[31:PC_W+2], ex_pc[1:0],
                           ex_target[31:PC_W+2], ex_target[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_INIT;
      r_sweep      <= '0;
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (r_state == S_INIT) begin
        r_sweep <= r_sweep + IDX_W'(1);
        if (r_sweep == {IDX_W{1'b1}}) begin
          r_state <= S_RUN;
        end
      end
      if (w_ex_act && ex_is_branch && (r_branch_cnt != {CNT_W{1'b1}})) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_fail && (r_miss_cnt != {CNT_W{1'b1}})) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  // Table contents are only ever initialised by the INIT sweep, never by rst_n
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_vld[r_sweep] <= 1'b0;
      r_ctr[r_sweep] <= 2'b01;
      r_tag[r_sweep] <= '0;
      r_tgt[r_sweep] <= '0;
    end else if (ex_valid) begin
      if (ex_is_branch) begin
        if (w_ex_hit) begin
          if (ex_taken) begin
            r_tgt[w_ex_idx] <= ex_target[PC_W+1:2];
            if (r_ctr[w_ex_idx] != 2'b11) begin
              r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
            end
          end else if (r_ctr[w_ex_idx] != 2'b00) begin
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          r_vld[w_ex_idx] <= 1'b1;
          r_tag[w_ex_idx] <= w_ex_tag;
          r_tgt[w_ex_idx] <= ex_target[PC_W+1:2];
          r_ctr[w_ex_idx] <= 2'b10;
        end
      end else if (w_ex_hit) begin
        r_vld[w_ex_idx] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bht_predictor.sv
// Randomised + directed bench for bht_predictor against an arithmetic reference model.
module tb_bht_predictor;
  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] pc_predict;
  logic        pred_taken;
  logic        ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        predict_fail;
  logic [31:0] pc_new;
  logic [15:0] branch_cnt;
  logic [15:0] miss_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  bht_predictor dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_predict(pc_predict),
    .pred_taken(pred_taken), .ready(ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .predict_fail(predict_fail),
    .pc_new(pc_new), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 64 entries, word index = (pc/4)%64, tag = (pc/256)%16
  bit          m_vld [64];
  int unsigned m_tag [64];
  int unsigned m_tgt [64];
  int unsigned m_ctr [64];
  int unsigned m_cyc = 0;
  int unsigned m_bc  = 0;
  int unsigned m_mc  = 0;

  function automatic int unsigned m_idx(input logic [31:0] a); return (a / 4) % 64; endfunction
  function automatic int unsigned m_tg(input logic [31:0] a);  return (a / 256) % 16; endfunction
  function automatic logic [31:0] m_seq(input logic [31:0] a); return ((a / 4 + 1) % 1024) * 4; endfunction
  function automatic bit m_ready(); return (rst_n === 1'b1) && (m_cyc >= 64); endfunction
  function automatic bit m_hit(input logic [31:0] a);
    return m_vld[m_idx(a)] && (m_tag[m_idx(a)] == m_tg(a));
  endfunction
  function automatic bit m_pt();
    return m_ready() && m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction
  function automatic logic [31:0] m_pp();
    return m_pt() ? m_tgt[m_idx(pc)] * 4 : m_seq(pc);
  endfunction
  function automatic bit m_fail();
    if (!m_ready() || !ex_valid) return 1'b0;
    if (ex_is_branch) return (ex_taken != ex_pred_taken) || (ex_taken && (ex_pred_target != ex_target));
    return ex_pred_taken;
  endfunction
  function automatic logic [31:0] m_new();
    if (!m_fail()) return 32'd0;
    if (ex_is_branch && ex_taken) return ((ex_target / 4) % 1024) * 4;
    return m_seq(ex_pc);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0;
      m_bc  = 0;
      m_mc  = 0;
    end else begin
      if (m_cyc >= 64 && ex_valid) begin
        automatic int unsigned i = m_idx(ex_pc);
        if (m_fail() && m_mc < 65535) m_mc++;
        if (ex_is_branch) begin
          if (m_bc < 65535) m_bc++;
          if (m_hit(ex_pc)) begin
            if (ex_taken) begin
              m_tgt[i] = (ex_target / 4) % 1024;
              if (m_ctr[i] < 3) m_ctr[i]++;
            end else if (m_ctr[i] > 0) m_ctr[i]--;
          end else if (ex_taken) begin
            m_vld[i] = 1'b1;
            m_tag[i] = m_tg(ex_pc);
            m_tgt[i] = (ex_target / 4) % 1024;
            m_ctr[i] = 2;
          end
        end else if (m_hit(ex_pc)) begin
          m_vld[i] = 1'b0;
        end
      end
      if (m_cyc < 64) begin
        m_cyc++;
        if (m_cyc == 64) begin
          for (int k = 0; k < 64; k++) begin
            m_vld[k] = 1'b0;
            m_ctr[k] = 1;
            m_tag[k] = 0;
            m_tgt[k] = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {31'd0, ready}, {31'd0, m_ready()});
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_pt()});
      chk("pc_predict", pc_predict, m_pp());
      chk("predict_fail", {31'd0, predict_fail}, {31'd0, m_fail()});
      chk("pc_new", pc_new, m_new());
      chk("branch_cnt", {16'd0, branch_cnt}, m_bc);
      chk("miss_cnt", {16'd0, miss_cnt}, m_mc);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input bit v, input bit br, input logic [31:0] a, input bit tk,
                        input logic [31:0] tg, input bit ptk, input logic [31:0] ptg);
    ex_valid = v; ex_is_branch = br; ex_pc = a; ex_taken = tk;
    ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
  endtask

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFC;
    return ($urandom_range(0, 3) * 64 + $urandom_range(0, 7)) * 4;
  endfunction

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    pc = 32'h100;
    ex_set(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;
    ex_set(1, 1, 32'h40, 1, 32'h200, 0, 32'h44);
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #2;
      if (k == 1) begin
        chk("init_pc_predict", pc_predict, 32'h104);
        chk("init_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("init_fail", {31'd0, predict_fail}, 32'd0);
      end
      if (k == 63) chk("ready_at_63", {31'd0, ready}, 32'd0);
      if (k == 64) chk("ready_at_64", {31'd0, ready}, 32'd1);
    end

    // First taken branch allocates
    chk("alloc_fail", {31'd0, predict_fail}, 32'd1);
    chk("alloc_pc_new", pc_new, 32'h200);
    nxt();
    ex_valid = 0; pc = 32'h40; #1;
    chk("hit_pt", {31'd0, pred_taken}, 32'd1);
    chk("hit_pp", pc_predict, 32'h200);
    chk("bc1", {16'd0, branch_cnt}, 32'd1);
    chk("mc1", {16'd0, miss_cnt}, 32'd1);

    // Two not-taken resolutions walk the counter down
    ex_set(1, 1, 32'h40, 0, 32'h200, 1, 32'h200); #1;
    chk("nt_fail", {31'd0, predict_fail}, 32'd1);
    chk("nt_pc_new", pc_new, 32'h44);
    chk("same_cycle_pt", {31'd0, pred_taken}, 32'd1);
    nxt();
    ex_pred_taken = 0; #1;
    chk("nt2_fail", {31'd0, predict_fail}, 32'd0);
    chk("nt2_pc_new", pc_new, 32'd0);
    nxt();
    ex_valid = 0; #1;
    chk("weak_pp", pc_predict, 32'h44);
    chk("weak_pt", {31'd0, pred_taken}, 32'd0);

    // Retrain taken, then alias and self non-branch
    ex_set(1, 1, 32'h40, 1, 32'h200, 0, 32'h0);
    nxt(); nxt();
    ex_valid = 0; #1;
    chk("retrain_pt", {31'd0, pred_taken}, 32'd1);
    ex_set(1, 0, 32'h140, 0, 32'h0, 0, 32'h0); #1;
    chk("alias_fail", {31'd0, predict_fail}, 32'd0);
    nxt();
    ex_valid = 0; #1;
    chk("alias_keep_pp", pc_predict, 32'h200);
    ex_set(1, 0, 32'h40, 0, 32'h0, 1, 32'h200); #1;
    chk("self_fail", {31'd0, predict_fail}, 32'd1);
    chk("self_pc_new", pc_new, 32'h44);
    nxt();
    ex_valid = 0; #1;
    chk("inval_pp", pc_predict, 32'h44);

    // Word wrap and target mismatch
    pc = 32'hFFC;
    ex_set(1, 1, 32'h80, 1, 32'h304, 1, 32'h300); #1;
    chk("wrap_pp", pc_predict, 32'h0);
    chk("tgt_fail", {31'd0, predict_fail}, 32'd1);
    chk("tgt_pc_new", pc_new, 32'h304);
    nxt();

    for (int n = 0; n < 3000; n++) begin
      pc = rnd_pc();
      a = rnd_pc();
      ex_set($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, a,
             $urandom_range(0, 1) == 1, rnd_pc(), $urandom_range(0, 1) == 1,
             ($urandom_range(0, 1) == 1) ? m_pp() : rnd_pc());
      if ($urandom_range(0, 2) == 0) begin
        ex_pred_taken = m_pt();
        ex_pred_target = m_pp();
        ex_pc = pc;
      end
      nxt();
    end

    // Mid-run reset: table must come back empty after the sweep
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_bc", {16'd0, branch_cnt}, 32'd0);
    chk("rst_mc", {16'd0, miss_cnt}, 32'd0);
    nxt();
    rst_n = 1'b1;
    ex_set(1, 1, 32'h40, 1, 32'h200, 0, 32'h0);
    repeat (64) nxt();
    ex_valid = 0;
    for (int t = 0; t < 4; t++) begin
      for (int w = 0; w < 8; w++) begin
        pc = (t * 64 + w) * 4; #1;
        chk("post_rst_pt", {31'd0, pred_taken}, 32'd0);
        chk("post_rst_pp", pc_predict, pc + 32'd4);
      end
    end
    pc = 32'hFFC; #1;
    chk("post_rst_wrap", pc_predict, 32'h0);
    nxt();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
